// File: rtl/line_buffer_3row_axis.sv
// rtl/line_buffer_3row_axis.sv - three-row vertical column buffer feeding the DPC 3x3 window
module line_buffer_3row_axis #(
    parameter int DATA_WIDTH = 10,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                  pixel_clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tuser,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] matrix_data01,
    output logic [DATA_WIDTH-1:0] matrix_data11,
    output logic [DATA_WIDTH-1:0] matrix_data21,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast,
    output logic                  line_len_err
);

    localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

    logic [DATA_WIDTH-1:0] line1 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] line2 [IMG_WIDTH];

    logic [AW-1:0]         col;
    logic [AW-1:0]         addr;
    logic [11:0]           row;
    logic [11:0]           row_cur;
    logic                  col_at_end;
    logic                  wrap_pend;

    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;
    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_pix;
    logic                  s1_user;
    logic                  s1_last;
    logic                  s1_row0;
    logic                  s1_row1;
    logic                  s1_ovf;

    // A start-of-frame beat is always column 0 / row 0, whatever the counters say.
    assign addr       = s_axis_tuser ? '0 : col;
    assign row_cur    = s_axis_tuser ? '0 : row;
    assign col_at_end = (addr == AW'(IMG_WIDTH - 1));

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            col       <= '0;
            row       <= '0;
            wrap_pend <= 1'b0;
        end else if (s_axis_tvalid) begin
            wrap_pend <= 1'b0;
            if (s_axis_tlast) begin
                col <= '0;
            end else if (col_at_end) begin
                col       <= '0;
                wrap_pend <= 1'b1;
            end else begin
                col <= addr + 1'b1;
            end
            if (s_axis_tlast) begin
                row <= (row_cur == 12'(IMG_HEIGHT - 1)) ? row_cur : row_cur + 12'd1;
            end else begin
                row <= row_cur;
            end
        end
    end

    // Line RAMs are never reset; row masking hides whatever they hold.
    always_ff @(posedge pixel_clk) begin
        if (s_axis_tvalid) begin
            rd1         <= line1[addr];
            rd2         <= line2[addr];
            line1[addr] <= s_axis_tdata;
            line2[addr] <= line1[addr];
        end
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_pix   <= '0;
            s1_user  <= 1'b0;
            s1_last  <= 1'b0;
            s1_row0  <= 1'b0;
            s1_row1  <= 1'b0;
            s1_ovf   <= 1'b0;
        end else begin
            s1_valid <= s_axis_tvalid;
            if (s_axis_tvalid) begin
                s1_pix  <= s_axis_tdata;
                s1_user <= s_axis_tuser;
                s1_last <= s_axis_tlast;
                s1_row0 <= (row_cur == 12'd0);
                s1_row1 <= (row_cur == 12'd1);
                // The beat landing on a wrapped column is the first one past the line end.
                s1_ovf  <= wrap_pend & ~s_axis_tuser;
            end
        end
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            matrix_data01 <= '0;
            matrix_data11 <= '0;
            matrix_data21 <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
            line_len_err  <= 1'b0;
        end else begin
            m_axis_tvalid <= s1_valid;
            m_axis_tuser  <= s1_valid & s1_user;
            m_axis_tlast  <= s1_valid & s1_last;
            if (s1_valid) begin
                matrix_data21 <= s1_pix;
                matrix_data11 <= s1_row0 ? '0 : rd1;
                matrix_data01 <= (s1_row0 | s1_row1) ? '0 : rd2;
                if (s1_user) begin
                    line_len_err <= 1'b0;
                end else if (s1_ovf) begin
                    line_len_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_line_buffer_3row_axis.sv
// tb/tb_line_buffer_3row_axis.sv - directed self-checking bench for line_buffer_3row_axis
module tb_line_buffer_3row_axis;

    localparam int DW = 10;
    localparam int W  = 8;
    localparam int H  = 4;

    logic          pixel_clk = 1'b0;
    logic          rst_n     = 1'b0;
    logic [DW-1:0] s_axis_tdata  = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tuser  = 1'b0;
    logic          s_axis_tlast  = 1'b0;
    logic [DW-1:0] matrix_data01;
    logic [DW-1:0] matrix_data11;
    logic [DW-1:0] matrix_data21;
    logic          m_axis_tvalid;
    logic          m_axis_tuser;
    logic          m_axis_tlast;
    logic          line_len_err;

    line_buffer_3row_axis #(
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .pixel_clk     (pixel_clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tlast  (s_axis_tlast),
        .matrix_data01 (matrix_data01),
        .matrix_data11 (matrix_data11),
        .matrix_data21 (matrix_data21),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .line_len_err  (line_len_err)
    );

    always #5 pixel_clk = ~pixel_clk;

    typedef struct {
        int d01;
        int d11;
        int d21;
        int u;
        int l;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   sb_on    = 1'b0;
    int   vcount   = 0;
    int   ucount   = 0;
    int   lcount   = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge pixel_clk) cyc = cyc + 1;

    always @(negedge pixel_clk) begin
        if (sb_on && m_axis_tvalid) begin
            vcount++;
            if (m_axis_tuser) ucount++;
            if (m_axis_tlast) lcount++;
            if (q.size() == 0) begin
                check("q_empty", q.size(), 1);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("data01", int'(matrix_data01), e.d01);
                check("data11", int'(matrix_data11), e.d11);
                check("data21", int'(matrix_data21), e.d21);
                check("tuser", int'(m_axis_tuser), e.u);
                check("tlast", int'(m_axis_tlast), e.l);
                check("latency", cyc, e.cyc);
                if (e.u != 0) check("err_clr", int'(line_len_err), 0);
            end
        end
    end

    task automatic beat(input int d, input bit u, input bit l, input bit v,
                        input int e01, input int e11, input int e21);
        exp_t e;
        s_axis_tdata  = v ? DW'(d) : 10'h3ff;
        s_axis_tuser  = v & u;
        s_axis_tlast  = v & l;
        s_axis_tvalid = v;
        if (v && sb_on) begin
            e.d01 = e01; e.d11 = e11; e.d21 = e21;
            e.u = int'(u); e.l = int'(l); e.cyc = cyc + 2;
            q.push_back(e);
        end
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
        repeat (n) begin
            @(posedge pixel_clk);
            #1;
        end
    endtask

    // Ramp pixel = 16*row + col; the column above is the same ramp shifted by 16 per row.
    task automatic frame(input bit toggle);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                beat(16*r + c, (r == 0 && c == 0), (c == W-1), 1'b1,
                     (r >= 2) ? 16*(r-2) + c : 0,
                     (r >= 1) ? 16*(r-1) + c : 0,
                     16*r + c);
                if (toggle) beat(0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
            end
        end
    endtask

    task automatic outputs_zero(input string tag);
        check({tag, "_d01"}, int'(matrix_data01), 0);
        check({tag, "_d11"}, int'(matrix_data11), 0);
        check({tag, "_d21"}, int'(matrix_data21), 0);
        check({tag, "_vld"}, int'(m_axis_tvalid), 0);
        check({tag, "_usr"}, int'(m_axis_tuser), 0);
        check({tag, "_lst"}, int'(m_axis_tlast), 0);
        check({tag, "_err"}, int'(line_len_err), 0);
    endtask

    initial begin
        #1;
        outputs_zero("rst");
        repeat (3) @(posedge pixel_clk);
        #1;
        rst_n = 1'b1;

        sb_on = 1'b1;
        frame(1'b0);
        idle(3);
        check("vcount", vcount, W*H);
        check("ucount", ucount, 1);
        check("lcount", lcount, H);

        frame(1'b0);
        frame(1'b1);
        idle(3);
        check("q_drain1", q.size(), 0);

        // Overlong line: ten beats, tlast on the tenth.
        sb_on = 1'b0;
        for (int i = 0; i < 10; i++) begin
            beat(i, (i == 0), (i == 9), 1'b1, 0, 0, 0);
            if (i == 8) check("err_pre", int'(line_len_err), 0);
            if (i == 9) check("err_rise", int'(line_len_err), 1);
        end
        idle(4);
        check("err_hold", int'(line_len_err), 1);

        sb_on = 1'b1;
        frame(1'b0);
        idle(3);
        check("err_after", int'(line_len_err), 0);
        check("q_drain2", q.size(), 0);

        // Reset partway through row 2.
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < ((r == 2) ? 4 : W); c++) begin
                beat(16*r + c, (r == 0 && c == 0), (c == W-1), 1'b1,
                     (r >= 2) ? 16*(r-2) + c : 0,
                     (r >= 1) ? 16*(r-1) + c : 0,
                     16*r + c);
            end
        end
        sb_on = 1'b0;
        q.delete();
        rst_n = 1'b0;
        s_axis_tvalid = 1'b0;
        #1;
        outputs_zero("mid_rst");
        idle(2);
        rst_n = 1'b1;
        sb_on = 1'b1;
        for (int c = 0; c < W; c++) beat(200 + c, 1'b0, (c == W-1), 1'b1, 0, 0, 200 + c);
        for (int c = 0; c < W; c++) beat(300 + c, 1'b0, (c == W-1), 1'b1, 0, 200 + c, 300 + c);
        idle(4);
        check("q_drain3", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
